// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: stereo FIFO, BCLK/LRCLK generation, MSB-first serializer.
// Define AUDIO_TX_HOLD_LAST_EN to repeat the last pair on underrun instead of silence.
module audio_i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [5:0]            bit_q, bit_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [PTR_W-1:0]      wr_q, wr_d;
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_r_q [FIFO_DEPTH];

  logic                  tick;
  logic                  fall;
  logic                  wrap;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [5:0]            bit_nx;
  logic [DATA_WIDTH-1:0] ch;
  logic [31:0]           word;

  assign tick   = (div_q == DIV_LAST);
  assign fall   = tick & bclk_q;
  assign wrap   = fall & (bit_q == 6'd63);
  assign empty  = (cnt_q == '0);
  assign push   = valid & ready_q;
  assign pop    = wrap & ~empty;
  assign bit_nx = bit_q + 6'd1;

  // Slot s of the 32-bit half frame maps to word bit 31-s; the sample sits
  // just below the leading zero that gives I2S its one-bit delay.
  assign ch   = bit_nx[5] ? hold_r_q : hold_l_q;
  assign word = 32'(ch) << (31 - DATA_WIDTH);

  always_comb begin
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    bclk_d     = tick ? ~bclk_q : bclk_q;
    bit_d      = bit_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    ready_d    = (cnt_d != FULL_CNT);
    if (push) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (fall) begin
      bit_d   = bit_nx;
      lrclk_d = bit_nx[5];
      sdata_d = word[5'd31 - bit_nx[4:0]];
    end
    if (wrap) begin
      if (empty) begin
        underrun_d = 1'b1;
`ifdef AUDIO_TX_HOLD_LAST_EN
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
`else
        hold_l_d = '0;
        hold_r_d = '0;
`endif
      end else begin
        hold_l_d = mem_l_q[rd_q];
        hold_r_d = mem_r_q[rd_q];
        rd_d     = rd_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      bit_q      <= 6'd63;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bit_q      <= bit_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l_q[wr_q] <= left_in;
      mem_r_q[wr_q] <= right_in;
    end
  end

  assign ready    = ready_q;
  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: random pushes, pair scoreboard, I2S frame decoder.
// Expected frames follow AUDIO_TX_HOLD_LAST_EN the same way the design does.
module tb_audio_i2s_tx;

  localparam int DW = 24;
  localparam int CD = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] left_in = '0;
  logic [DW-1:0] right_in = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic          underrun;

  audio_i2s_tx #(
    .DATA_WIDTH(DW),
    .CLK_DIV(CD),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .left_in(left_in),
    .right_in(right_in),
    .valid(valid),
    .ready(ready),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            tag;
  } pair_t;

  pair_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rdy_ok = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decodes the I2S stream and compares whole frames.
  int            slot = 63;
  logic          pb = 0, pl = 0, ps = 0;
  int            last_fall = -1;
  bit            fa = 0;
  logic [63:0]   rec = '0, expf = '0;
  logic [DW-1:0] last_l = '0, last_r = '0;

  always @(negedge clk) begin
    bit    fell;
    bit    exp_ur;
    pair_t p;
    if (!reset_n) begin
      chk("reset_outputs", {59'd0, ready, bclk, lrclk, sdata, underrun}, 64'd0);
      slot = 63; pb = 0; pl = 0; ps = 0;
      last_fall = -1; fa = 0;
      last_l = '0; last_r = '0;
    end else begin
      fell = pb && !bclk;
      if (fell) begin
        slot = (slot + 1) % 64;
        if (last_fall >= 0) chk("bclk_period", 64'(cyc - last_fall), 64'(2 * CD));
        last_fall = cyc;
        chk("lrclk_slot", 64'(lrclk), 64'(slot >= 32));
        if (slot == 0) begin
          exp_ur = !(q.size() > 0 && q[0].tag < cyc);
          chk("underrun", 64'(underrun), 64'(exp_ur));
          if (!exp_ur) begin
            p = q.pop_front();
            last_l = p.l;
            last_r = p.r;
          end else begin
`ifndef AUDIO_TX_HOLD_LAST_EN
            last_l = '0;
            last_r = '0;
`endif
          end
          expf = {1'b0, last_l, 7'd0, 1'b0, last_r, 7'd0};
          fa = 1;
          rec = '0;
        end else begin
          chk("underrun_midframe", 64'(underrun), 64'd0);
        end
        if (fa) rec[63 - slot] = sdata;
        if (fa && slot == 63) chk("frame", rec, expf);
      end else begin
        if (underrun) chk("underrun_stray", 64'(underrun), 64'd0);
        if (lrclk !== pl) chk("lrclk_glitch", 64'(lrclk), 64'(pl));
        if (sdata !== ps) chk("sdata_glitch", 64'(sdata), 64'(ps));
      end
      pb = bclk; pl = lrclk; ps = sdata;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Runs at negedge+1: ready is stable until the next posedge.
  task automatic drive(bit v, logic [DW-1:0] l, logic [DW-1:0] r);
    if (reset_n && rdy_ok) chk("ready", 64'(ready), 64'(q.size() < FD));
    valid = v;
    left_in = l;
    right_in = r;
    if (v && ready) q.push_back('{l, r, cyc + 1});
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, '0, '0);
  endtask

  task automatic wait_slot(int s);
    int k;
    k = 0;
    while (slot != s && k < 2200) begin
      drive(0, '0, '0);
      k++;
    end
    if (slot != s) chk("wait_slot_timeout", 64'(slot), 64'(s));
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    reset_n = 1;
    step();
    chk("ready_after_reset", 64'(ready), 64'd1);
    rdy_ok = 1;
    idle(2100);

    wait_slot(2);
    drive(1, 24'hA5F00F, 24'h800001);
    idle(2100);

    wait_slot(2);
    for (int i = 0; i < 5; i++) drive(1, DW'($urandom), DW'($urandom));
    chk("ready_full", 64'(ready), 64'd0);
    chk("fifo_depth", 64'(q.size()), 64'(FD));
    idle(6200);

    wait_slot(2);
    drive(1, 24'h123456, 24'h654321);
    idle(3100);

    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 349) == 0) drive(1, DW'($urandom), DW'($urandom));
      else drive(0, '0, '0);
    end

    k = 0;
    while (q.size() != 0 && k < 6000) begin
      drive(0, '0, '0);
      k++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    wait_slot(2);
    drive(1, DW'($urandom), DW'($urandom));
    drive(1, DW'($urandom), DW'($urandom));
    wait_slot(40);
    chk("queued_before_reset", 64'(q.size()), 64'd2);
    reset_n = 0;
    #1;
    chk("async_reset", {59'd0, ready, bclk, lrclk, sdata, underrun}, 64'd0);
    valid = 0;
    q.delete();
    rdy_ok = 0;
    step();
    step();
    reset_n = 1;
    step();
    rdy_ok = 1;
    idle(2100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
